fwd_hazard_unit: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the MIPS pipeline cores. It sits beside the EX stage of each core. Internally it keeps a shift register of in-flight destination records, one per downstream stage. Each cycle it produces the bus-A/bus-B operand select codes and a stall request. It generalises the fixed two-source forwarding encoding to DEPTH forwarding stages with per-instruction result-ready latency, and adds a stall performance counter.

---
 rtl/fwd_hazard_unit.sv | 87 ++++++++
 tb/tb_fwd_hazard_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit for the EX stage.
// Tracks in-flight destinations per downstream stage and picks the youngest ready source.
module fwd_hazard_unit #(
   parameter int DEPTH      = 2,
   parameter int LOAD_STAGE = 2,
   parameter int REG_W      = 5,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = $clog2(DEPTH + 2)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             hold,
   input  logic             flush,
   input  logic             ex_valid,
   input  logic [REG_W-1:0] ex_rs,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic             ex_use_imm,
   output logic [SEL_W-1:0] sel_a,
   output logic [SEL_W-1:0] sel_b,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   localparam int RDY_W = $clog2(DEPTH + 1);

   // Index k is the stage number: 1 = EX/MEM, DEPTH = oldest.
   logic             rec_valid [1:DEPTH];
   logic [REG_W-1:0] rec_rd    [1:DEPTH];
   logic [RDY_W-1:0] rec_rdy   [1:DEPTH];

   logic [SEL_W-1:0] fwd_a, fwd_b;
   logic             found_a, found_b;
   logic             wait_a, wait_b;
   logic [RDY_W-1:0] ex_rdy;

   assign ex_rdy = ex_memread ? RDY_W'(LOAD_STAGE) : RDY_W'(1);

   // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      fwd_a   = '0;
      fwd_b   = '0;
      found_a = 1'b0;
      found_b = 1'b0;
      wait_a  = 1'b0;
      wait_b  = 1'b0;
      // Ascending scan with a found flag: the youngest match wins, older ones are ignored.
      for (int k = 1; k <= DEPTH; k++) begin
         if (!found_a && ex_rs != '0 && rec_valid[k] && rec_rd[k] == ex_rs) begin
            found_a = 1'b1;
            if (k >= int'(rec_rdy[k])) fwd_a = SEL_W'(k + 1);
            else                       wait_a = 1'b1;
         end
         if (!found_b && ex_rt != '0 && rec_valid[k] && rec_rd[k] == ex_rt) begin
            found_b = 1'b1;
            if (k >= int'(rec_rdy[k])) fwd_b = SEL_W'(k + 1);
            else                       wait_b = 1'b1;
         end
      end
   end

   assign stall = ex_valid && !flush && (wait_a || (wait_b && !ex_use_imm));
   assign sel_a = fwd_a;
   assign sel_b = ex_use_imm ? SEL_W'(1) : fwd_b;

   // NOTE: only the valid bits and counter need reset; rd/ready are ignored while invalid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 1; k <= DEPTH; k++) rec_valid[k] <= 1'b0;
         stall_count <= '0;
      end else if (!hold) begin
         // NOTE: non-blocking assignments make the shift read every stage's old value.
         for (int k = DEPTH; k >= 2; k--) begin
            rec_valid[k] <= rec_valid[k-1];
            rec_rd[k]    <= rec_rd[k-1];
            rec_rdy[k]   <= rec_rdy[k-1];
         end
         rec_valid[1] <= ex_valid && ex_regwrite && !stall && !flush;
         rec_rd[1]    <= ex_rd;
         rec_rdy[1]   <= ex_rdy;
         if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: a per-cycle vector table for DEPTH=2 and a hand sequence
// for a DEPTH=4 / LOAD_STAGE=3 / CNT_W=2 instance.
module tb_fwd_hazard_unit;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   // DEPTH=2 instance
   logic       hold, flush, ex_valid, ex_regwrite, ex_memread, ex_use_imm;
   logic [4:0] ex_rs, ex_rt, ex_rd;
   logic [1:0] sel_a, sel_b;
   logic       stall;
   logic [15:0] stall_count;

   fwd_hazard_unit #(.DEPTH(2), .LOAD_STAGE(2), .REG_W(5), .CNT_W(16)) u_d2 (
      .CLK(CLK), .RST(RST), .hold(hold), .flush(flush), .ex_valid(ex_valid),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_use_imm(ex_use_imm),
      .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_count(stall_count)
   );

   // DEPTH=4, LOAD_STAGE=3, CNT_W=2 instance
   logic       d4_valid, d4_regwrite, d4_memread;
   logic [4:0] d4_rs, d4_rd;
   logic [2:0] d4_sel_a, d4_sel_b;
   logic       d4_stall;
   logic [1:0] d4_count;

   fwd_hazard_unit #(.DEPTH(4), .LOAD_STAGE(3), .REG_W(5), .CNT_W(2)) u_d4 (
      .CLK(CLK), .RST(RST), .hold(1'b0), .flush(1'b0), .ex_valid(d4_valid),
      .ex_rs(d4_rs), .ex_rt(5'd0), .ex_rd(d4_rd), .ex_regwrite(d4_regwrite),
      .ex_memread(d4_memread), .ex_use_imm(1'b0),
      .sel_a(d4_sel_a), .sel_b(d4_sel_b), .stall(d4_stall), .stall_count(d4_count)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst, hold, flush, v;
      logic [4:0] rs, rt, rd;
      logic       rw, mr, imm;
      int         sa, sb, st, cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst_i, hold_i, flush_i, v_i,
                               input int rs_i, rt_i, rd_i,
                               input logic rw_i, mr_i, imm_i,
                               input int sa_i, sb_i, st_i, cnt_i);
      vec_t r;
      r.rst = rst_i; r.hold = hold_i; r.flush = flush_i; r.v = v_i;
      r.rs = 5'(rs_i); r.rt = 5'(rt_i); r.rd = 5'(rd_i);
      r.rw = rw_i; r.mr = mr_i; r.imm = imm_i;
      r.sa = sa_i; r.sb = sb_i; r.st = st_i; r.cnt = cnt_i;
      return r;
   endfunction

   task automatic d4_cycle(input int rs, input int rd, input logic rw, input logic mr,
                           input int exp_sa, input int exp_st, input int exp_cnt, input string tag);
      @(negedge CLK);
      d4_valid = 1'b1; d4_rs = 5'(rs); d4_rd = 5'(rd); d4_regwrite = rw; d4_memread = mr;
      #1;
      check({tag, ".sel_a"}, 32'(d4_sel_a), 32'(exp_sa));
      check({tag, ".stall"}, 32'(d4_stall), 32'(exp_st));
      check({tag, ".count"}, 32'(d4_count), 32'(exp_cnt));
   endtask

   initial begin
      // rst hold flush v | rs rt rd | rw mr imm | sa sb st cnt
      vecs.push_back(mk(0,0,0,0, 0,0,0, 0,0,1, 0,1,0,0)); // reset state
      vecs.push_back(mk(0,0,0,1, 1,2,3, 1,0,0, 0,0,0,0)); // add r3
      vecs.push_back(mk(0,0,0,1, 3,3,5, 1,0,0, 2,2,0,0)); // add r5,r3,r3
      vecs.push_back(mk(0,0,0,1, 3,0,0, 0,0,0, 3,0,0,0)); // r3 two back
      vecs.push_back(mk(0,0,0,1, 0,0,4, 1,1,0, 0,0,0,0)); // lw r4
      vecs.push_back(mk(0,0,0,1, 4,1,6, 1,0,0, 0,0,1,0)); // sub stalls
      vecs.push_back(mk(0,0,0,1, 4,1,6, 1,0,0, 3,0,0,1)); // sub from WB
      vecs.push_back(mk(0,0,0,1, 0,0,5, 1,0,0, 0,0,0,1)); // add r5
      vecs.push_back(mk(0,0,0,1, 0,0,5, 1,0,0, 0,0,0,1)); // add r5
      vecs.push_back(mk(0,0,0,1, 5,5,0, 0,0,1, 2,1,0,1)); // youngest r5, imm
      vecs.push_back(mk(0,0,0,1, 0,0,0, 1,0,0, 0,0,0,1)); // write r0
      vecs.push_back(mk(0,0,0,1, 0,0,0, 0,0,0, 0,0,0,1)); // read r0
      vecs.push_back(mk(0,0,0,1, 0,0,7, 1,1,0, 0,0,0,1)); // lw r7
      vecs.push_back(mk(0,0,0,1, 1,7,8, 1,0,1, 0,1,0,1)); // imm hides rt hazard
      vecs.push_back(mk(0,0,0,1, 0,0,4, 1,1,0, 0,0,0,1)); // lw r4
      vecs.push_back(mk(0,1,0,1, 4,1,6, 1,0,0, 0,0,1,1)); // held stall
      vecs.push_back(mk(0,1,0,1, 4,1,6, 1,0,0, 0,0,1,1));
      vecs.push_back(mk(0,1,0,1, 4,1,6, 1,0,0, 0,0,1,1));
      vecs.push_back(mk(0,0,0,1, 4,1,6, 1,0,0, 0,0,1,1)); // released
      vecs.push_back(mk(0,0,0,1, 4,1,6, 1,0,0, 3,0,0,2));
      vecs.push_back(mk(0,0,0,1, 0,0,4, 1,1,0, 0,0,0,2)); // lw r4
      vecs.push_back(mk(1,0,0,1, 4,1,6, 1,0,0, 0,0,1,2)); // reset mid-stall
      vecs.push_back(mk(0,0,0,1, 4,1,6, 1,0,0, 0,0,0,0)); // cleared
      vecs.push_back(mk(0,0,0,1, 0,0,4, 1,1,0, 0,0,0,0)); // lw r4
      vecs.push_back(mk(0,0,1,1, 4,1,6, 1,0,0, 0,0,0,0)); // flush beats stall
      vecs.push_back(mk(0,0,0,1, 6,4,0, 0,0,0, 0,3,0,0)); // stage 1 is a bubble
      vecs.push_back(mk(0,0,0,1, 0,0,4, 1,1,0, 0,0,0,0)); // lw r4
      vecs.push_back(mk(0,0,0,0, 4,0,0, 0,0,0, 0,0,0,0)); // invalid EX never stalls

      hold = 0; flush = 0; ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
      ex_regwrite = 0; ex_memread = 0; ex_use_imm = 0;
      d4_valid = 0; d4_rs = 0; d4_rd = 0; d4_regwrite = 0; d4_memread = 0;
      RST = 1'b1;
      repeat (2) @(posedge CLK);

      foreach (vecs[i]) begin
         @(negedge CLK);
         RST = vecs[i].rst; hold = vecs[i].hold; flush = vecs[i].flush;
         ex_valid = vecs[i].v; ex_rs = vecs[i].rs; ex_rt = vecs[i].rt; ex_rd = vecs[i].rd;
         ex_regwrite = vecs[i].rw; ex_memread = vecs[i].mr; ex_use_imm = vecs[i].imm;
         #1;
         check($sformatf("v%0d.sel_a", i), 32'(sel_a), 32'(vecs[i].sa));
         check($sformatf("v%0d.sel_b", i), 32'(sel_b), 32'(vecs[i].sb));
         check($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].st));
         check($sformatf("v%0d.count", i), 32'(stall_count), 32'(vecs[i].cnt));
      end
      @(negedge CLK);
      RST = 1'b0; ex_valid = 1'b0; hold = 1'b0; flush = 1'b0;

      // Deep pipeline: two-cycle load-use stall, forwarding from stages 3 and 4,
      // discard past DEPTH, and counter saturation at 3 after six stalls.
      d4_cycle(0, 4, 1, 1, 0, 0, 0, "d4.lw1");
      d4_cycle(4, 6, 1, 0, 0, 1, 0, "d4.use1a");
      d4_cycle(4, 6, 1, 0, 0, 1, 1, "d4.use1b");
      d4_cycle(4, 6, 1, 0, 4, 0, 2, "d4.use1c");
      d4_cycle(4, 0, 0, 0, 5, 0, 2, "d4.stage4");
      d4_cycle(4, 0, 0, 0, 0, 0, 2, "d4.gone");
      d4_cycle(0, 9, 1, 1, 0, 0, 2, "d4.lw2");
      d4_cycle(9, 6, 1, 0, 0, 1, 2, "d4.use2a");
      d4_cycle(9, 6, 1, 0, 0, 1, 3, "d4.use2b");
      d4_cycle(9, 6, 1, 0, 4, 0, 3, "d4.use2c");
      d4_cycle(0, 10, 1, 1, 0, 0, 3, "d4.lw3");
      d4_cycle(10, 6, 1, 0, 0, 1, 3, "d4.use3a");
      d4_cycle(10, 6, 1, 0, 0, 1, 3, "d4.use3b");
      d4_cycle(10, 6, 1, 0, 4, 0, 3, "d4.use3c");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
